// File: rtl/frame_egress_reader.sv
// Streams stored frames out of the frame buffer onto an AXI-stream master, one frame per
// sideband descriptor. Define EGRESS_FRAME_COUNT_EN to add the frames_sent counter output.
module frame_egress_reader #(
  parameter int unsigned ADDR_WIDTH      = 11,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned AXIS_DEST_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sb_empty,
  output logic                       sb_ren,
  input  logic [19:0]                sb_rdata,
  output logic                       fb_ren,
  output logic [ADDR_WIDTH:0]        fb_raddr,
  input  logic [DATA_WIDTH:0]        fb_rdata,
  output logic [ADDR_WIDTH:0]        frame_rptr,
  output logic [DATA_WIDTH-1:0]      m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [AXIS_DEST_WIDTH-1:0] m_tdest,
`ifdef EGRESS_FRAME_COUNT_EN
  output logic [31:0]                frames_sent,
`endif
  output logic                       busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StStream} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH:0]        raddr_q, rptr_q;
  logic [AXIS_DEST_WIDTH-1:0] dest_q;
  logic                       rvalid_q, last_seen_q;
  logic [DATA_WIDTH:0]        skid_q [2];
  logic                       wr_idx_q, rd_idx_q;
  logic [1:0]                 occ_q;

  logic push, pop, last_now, room, frame_done, sb_unused;

  // Only the dest and pointer fields of the sideband word carry meaning.
  assign sb_unused  = ^sb_rdata;
  assign push       = rvalid_q;
  assign pop        = m_tvalid & m_tready;
  assign last_now   = rvalid_q & fb_rdata[DATA_WIDTH];
  assign frame_done = pop & m_tlast;
  // A new read may only issue if it is guaranteed a free skid slot when it returns.
  assign room = ({1'b0, occ_q} + {2'b00, rvalid_q}) < (3'd2 + {2'b00, pop});

  always_comb begin
    state_d = state_q;
    sb_ren  = 1'b0;
    fb_ren  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!sb_empty) begin
          sb_ren  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: state_d = StStream;
      StStream: begin
        fb_ren = room & ~last_seen_q & ~last_now;
        if (frame_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raddr_q     <= '0;
      rptr_q      <= '0;
      dest_q      <= '0;
      rvalid_q    <= 1'b0;
      last_seen_q <= 1'b0;
      skid_q[0]   <= '0;
      skid_q[1]   <= '0;
      wr_idx_q    <= 1'b0;
      rd_idx_q    <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      rvalid_q <= fb_ren;
      if (state_q == StLoad) begin
        raddr_q     <= sb_rdata[ADDR_WIDTH+AXIS_DEST_WIDTH:AXIS_DEST_WIDTH];
        dest_q      <= sb_rdata[AXIS_DEST_WIDTH-1:0];
        last_seen_q <= 1'b0;
      end else begin
        if (fb_ren)   raddr_q     <= raddr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        if (last_now) last_seen_q <= 1'b1;
      end
      if (push) begin
        skid_q[wr_idx_q] <= fb_rdata;
        wr_idx_q         <= ~wr_idx_q;
      end
      if (pop) rd_idx_q <= ~rd_idx_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
      if (frame_done) rptr_q <= raddr_q;
    end
  end

`ifdef EGRESS_FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)           frames_sent <= '0;
    else if (frame_done) frames_sent <= frames_sent + 32'd1;
  end
`endif

  assign fb_raddr   = raddr_q;
  assign frame_rptr = rptr_q;
  assign m_tdest    = dest_q;
  assign m_tvalid   = (occ_q != 2'd0);
  assign m_tdata    = skid_q[rd_idx_q][DATA_WIDTH-1:0];
  assign m_tlast    = m_tvalid & skid_q[rd_idx_q][DATA_WIDTH];
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_frame_egress_reader.sv
// Self-checking bench for frame_egress_reader: a queue-based frame model plus directed and
// randomized frames with random back-pressure.
module tb_frame_egress_reader;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sb_empty = 1'b1;
  logic          sb_ren;
  logic [19:0]   sb_rdata = '0;
  logic          fb_ren;
  logic [AW:0]   fb_raddr;
  logic [DW:0]   fb_rdata = '0;
  logic [AW:0]   frame_rptr;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [TW-1:0] m_tdest;
  logic          busy;
`ifdef EGRESS_FRAME_COUNT_EN
  logic [31:0]   frames_sent;
`endif

  frame_egress_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXIS_DEST_WIDTH(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .sb_empty   (sb_empty),
    .sb_ren     (sb_ren),
    .sb_rdata   (sb_rdata),
    .fb_ren     (fb_ren),
    .fb_raddr   (fb_raddr),
    .fb_rdata   (fb_rdata),
    .frame_rptr (frame_rptr),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .m_tdest    (m_tdest),
`ifdef EGRESS_FRAME_COUNT_EN
    .frames_sent(frames_sent),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Environment: frame buffer memory and sideband FIFO with 1-cycle read latency.
  logic [DW:0]    mem [2**AW];
  logic [19:0]    sbq [$];
  // Model: reads, beats {data,last,dest} and release pointers in the order they must occur.
  logic [AW:0]    exp_reads [$];
  logic [DW+TW:0] exp_beats [$];
  logic [AW:0]    exp_rptr [$];
  int             frames_done = 0;

  always @(posedge clk) begin
    if (fb_ren) fb_rdata <= mem[fb_raddr[AW-1:0]];
    else        fb_rdata <= (DW+1)'($urandom);
    if (sb_ren && !reset) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL sb_underflow: sb_ren with empty sideband FIFO (t=%0t)", $time);
      end else begin
        sb_rdata <= sbq.pop_front();
        sb_empty <= (sbq.size() == 0);
      end
    end
  end

  int rdy_mode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 9) < 7);
    endcase
  end

  task automatic push_frame(input logic [AW:0] ptr, input logic [TW-1:0] dest, input int n,
                            input logic [DW-1:0] base, input bit rnd);
    logic [AW:0]   a;
    logic [DW-1:0] d;
    logic          l;
    for (int i = 0; i < n; i++) begin
      a = ptr + (AW+1)'(i);
      d = rnd ? DW'($urandom) : base + DW'(i);
      l = (i == n - 1);
      mem[a[AW-1:0]] = {l, d};
      exp_reads.push_back(a);
      exp_beats.push_back({d, l, dest});
    end
    exp_rptr.push_back(ptr + (AW+1)'(n));
    sbq.push_back({4'($urandom), ptr, dest});
    sb_empty = 1'b0;
  endtask

  // Per-cycle comparison of the DUT against the model.
  logic [AW:0]    rptr_model = '0;
  logic           stall_prev = 1'b0;
  logic [DW+TW:0] held;
  logic [DW+TW:0] e;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
      rptr_model = '0;
    end else begin
      check("frame_rptr", frame_rptr, rptr_model);
      if (stall_prev) begin
        check("stall_tvalid", m_tvalid, 1);
        check("stall_hold", {m_tdata, m_tlast, m_tdest}, held);
      end
      if (fb_ren) begin
        if (exp_reads.size() == 0) begin
          total++;
          $display("FAIL fb_read: unexpected fb_ren at %0h, none required", fb_raddr);
        end else check("fb_raddr", fb_raddr, exp_reads.pop_front());
      end
      if (m_tvalid && m_tready) begin
        if (exp_beats.size() == 0) begin
          total++;
          $display("FAIL beat: unexpected beat %0h, none required", m_tdata);
        end else begin
          e = exp_beats.pop_front();
          check("beat", {m_tdata, m_tlast, m_tdest}, e);
          if (e[TW]) begin
            rptr_model = exp_rptr.pop_front();
            frames_done++;
          end
        end
      end
      stall_prev = m_tvalid && !m_tready;
      held       = {m_tdata, m_tlast, m_tdest};
    end
  end

  logic [31:0] obs_seq;
  logic [47:0] obs_raddr;
  logic [TW-1:0] obs_dest;
  int obs_beats, c_sbren, c_fbren, c_tvalid, c_first, c_last;

  task automatic run_frames(input int n, input int budget);
    int target;
    int c;
    target = frames_done + n;
    obs_seq = '0; obs_raddr = '0; obs_dest = '0; obs_beats = 0;
    c_sbren = -1; c_fbren = -1; c_tvalid = -1; c_first = -1; c_last = -1;
    c = 0;
    while (frames_done < target && c < budget) begin
      @(negedge clk);
      if (sb_ren && c_sbren < 0) c_sbren = c;
      if (fb_ren) begin
        obs_raddr = {obs_raddr[35:0], fb_raddr};
        if (c_fbren < 0) c_fbren = c;
      end
      if (m_tvalid && c_tvalid < 0) c_tvalid = c;
      if (m_tvalid && m_tready) begin
        obs_seq = {obs_seq[23:0], m_tdata};
        obs_beats++;
        if (m_tlast) obs_dest = m_tdest;
        if (c_first < 0) c_first = c;
        c_last = c;
      end
      c++;
    end
    check("frames_within_budget", (frames_done >= target), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int cnt;
    int c;
    int nf;
    int len;
    int exp_n;
    logic [AW:0] cursor;
    logic [AW:0] last_end;
`ifdef EGRESS_FRAME_COUNT_EN
    logic [31:0] fs0;
`endif
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sb_ren", sb_ren, 0);
    check("rst_fb_ren", fb_ren, 0);
    check("rst_fb_raddr", fb_raddr, 0);
    check("rst_frame_rptr", frame_rptr, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tdest", m_tdest, 0);
    check("rst_busy", busy, 0);
`ifdef EGRESS_FRAME_COUNT_EN
    check("rst_frames_sent", frames_sent, 0);
`endif
    @(posedge clk); #1 reset = 1'b0;

    // Empty sideband: nothing happens
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (sb_ren || fb_ren || m_tvalid) bad++;
    end
    check("idle_quiet_cycles", bad, 0);

    // Basic 4-word frame, ready always high
    @(posedge clk); #1;
    push_frame(12'h010, 4'd2, 4, 8'hA0, 0);
    run_frames(1, 200);
    check("lat_fb_ren", c_fbren - c_sbren, 2);
    check("lat_tvalid", c_tvalid - c_sbren, 4);
    check("beats_back_to_back", c_last - c_first, 3);
    check("basic_beats", obs_beats, 4);
    check("basic_data", obs_seq, 32'hA0A1A2A3);
    check("basic_dest", obs_dest, 2);
    check("basic_rptr", frame_rptr, 12'h014);

    // Same frame with ready toggling
    rdy_mode = 1;
    @(posedge clk); #1;
    push_frame(12'h010, 4'd2, 4, 8'hA0, 0);
    run_frames(1, 200);
    check("toggle_beats", obs_beats, 4);
    check("toggle_data", obs_seq, 32'hA0A1A2A3);
    rdy_mode = 0;

    // Two queued descriptors
`ifdef EGRESS_FRAME_COUNT_EN
    fs0 = frames_sent;
`endif
    @(posedge clk); #1;
    push_frame(12'h000, 4'd1, 3, 8'hB0, 0);
    push_frame(12'h003, 4'd5, 1, 8'hC0, 0);
    run_frames(2, 200);
    check("two_frame_beats", obs_beats, 4);
    check("two_frame_data", obs_seq, 32'hB0B1B2C0);
    check("two_frame_last_dest", obs_dest, 5);
    check("two_frame_rptr", frame_rptr, 12'h004);
`ifdef EGRESS_FRAME_COUNT_EN
    check("frames_sent_delta", frames_sent - fs0, 2);
`endif

    // Frame across the physical wrap boundary
    @(posedge clk); #1;
    push_frame(12'h7FE, 4'd3, 4, 8'hD0, 0);
    run_frames(1, 200);
    check("wrap_raddr_seq", obs_raddr, 48'h7FE_7FF_800_801);
    check("wrap_rptr", frame_rptr, 12'h802);

    // Reset mid-frame
    @(posedge clk); #1;
    push_frame(12'h100, 4'd7, 8, 8'h50, 0);
    cnt = 0;
    c = 0;
    while (cnt < 2 && c < 50) begin
      @(negedge clk);
      if (m_tvalid && m_tready) cnt++;
      c++;
    end
    check("beats_before_reset", cnt, 2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tvalid", m_tvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rptr", frame_rptr, 0);
    check("midrst_raddr", fb_raddr, 0);
    exp_reads.delete();
    exp_beats.delete();
    exp_rptr.delete();
    sbq.delete();
    sb_empty = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_tvalid || busy || fb_ren) bad++;
    end
    check("no_resume_after_reset", bad, 0);

    // Randomized frames with random back-pressure, crossing the wrap-bit rollover
    rdy_mode = 2;
    cursor = 12'hFF8;
    for (int b = 0; b < 30; b++) begin
      @(posedge clk); #1;
      nf = $urandom_range(1, 3);
      exp_n = 0;
      for (int f = 0; f < nf; f++) begin
        len = $urandom_range(1, 8);
        push_frame(cursor, TW'($urandom), len, 8'h00, 1);
        last_end = cursor + (AW+1)'(len);
        exp_n += len;
        cursor = last_end + (AW+1)'($urandom_range(0, 3));
      end
      run_frames(nf, 400);
      check("rand_beats", obs_beats, exp_n);
      check("rand_rptr", frame_rptr, last_end);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    check("model_beats_drained", exp_beats.size(), 0);
    check("model_reads_drained", exp_reads.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
